overture_sequencer: RTL and testbench

//  Control/operand stage directly upstream of the ALU. Fetches instruction bytes from program memory, decodes the
//  2-bit mode field and holds the register file (r0..r5). Drives the ALU opcode and operands and writes the ALU

---
 rtl/overture_pkg.sv | 42 ++++
 rtl/overture_cond_eval.sv | 34 +++
 rtl/overture_sequencer.sv | 173 +++++++++++++++++
 tb/tb_overture_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overture_pkg.sv
// Shared encodings for the overture sequencer: instruction modes, ALU ops,
// jump conditions, special register indices and FSM states.
package overture_pkg;

    localparam logic [2:0] IO_IDX   = 3'd6;
    localparam logic [2:0] NULL_IDX = 3'd7;

    typedef enum logic [1:0] {
        MODE_IMM  = 2'd0,
        MODE_CALC = 2'd1,
        MODE_COPY = 2'd2,
        MODE_COND = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ALU_OR   = 3'd0,
        ALU_NAND = 3'd1,
        ALU_NOR  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_ADD  = 3'd4,
        ALU_SUB  = 3'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'd0,
        COND_EQZ    = 3'd1,
        COND_LTZ    = 3'd2,
        COND_LEZ    = 3'd3,
        COND_ALWAYS = 3'd4,
        COND_NEZ    = 3'd5,
        COND_GEZ    = 3'd6,
        COND_GTZ    = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WAIT_IN  = 2'd2,
        ST_WAIT_OUT = 2'd3
    } state_e;

endpackage

// File: rtl/overture_cond_eval.sv
// Jump condition evaluator: tests a value as signed two's complement
// against one of eight condition codes.
module overture_cond_eval
    import overture_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    input  logic [2:0]   cond,
    output logic         taken
);

    logic is_zero;
    logic is_neg;

    assign is_zero = (value == '0);
    assign is_neg  = value[W-1];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NEVER:  taken = 1'b0;
            COND_EQZ:    taken = is_zero;
            COND_LTZ:    taken = is_neg;
            COND_LEZ:    taken = is_neg | is_zero;
            COND_ALWAYS: taken = 1'b1;
            COND_NEZ:    taken = ~is_zero;
            COND_GEZ:    taken = ~is_neg;
            COND_GTZ:    taken = ~is_neg & ~is_zero;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/overture_sequencer.sv
// Control/operand stage ahead of the ALU: fetches instruction bytes, holds
// r0..r5, writes ALU results to r3, moves data between registers and IO, jumps.
module overture_sequencer
    import overture_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PC_WIDTH   = 8,
    parameter int NUM_REGS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PC_WIDTH-1:0]   imem_addr,
    output logic                  imem_req,
    input  logic                  imem_ack,
    input  logic [7:0]            imem_data,
    output logic [7:0]            alu_instr,
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   dbg_pc
);

    // Both IO ports use valid/ready: a word moves on the rising edge where
    // valid and ready are both high; the producer holds data stable until then.

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [7:0]            ir_q, ir_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    mode_e                 mode;
    logic [2:0]            src_idx;
    logic [2:0]            dst_idx;
    logic                  src_is_io;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [DATA_WIDTH-1:0] copy_val;
    logic                  cond_taken;
    logic                  xfer;

    assign mode      = mode_e'(ir_q[7:6]);
    assign src_idx   = ir_q[5:3];
    assign dst_idx   = ir_q[2:0];
    assign src_is_io = (src_idx == IO_IDX);
    assign pc_inc    = pc_q + 1'b1;

    overture_cond_eval #(.W(DATA_WIDTH)) u_cond_eval (
        .value (regs_q[3]),
        .cond  (ir_q[2:0]),
        .taken (cond_taken)
    );

    assign imem_addr = pc_q;
    assign dbg_pc    = pc_q;
    assign alu_instr = ir_q;
    assign alu_in1   = regs_q[1];
    assign alu_in2   = regs_q[2];
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    // Gated by rst so neither request leaks out while reset is held.
    assign imem_req  = rst && (state_q == ST_FETCH);
    assign in_ready  = rst && ((state_q == ST_WAIT_IN) ||
                               (state_q == ST_EXEC && mode == MODE_COPY && src_is_io));

    always_comb begin
        copy_val = '0;
        if (src_is_io) begin
            copy_val = in_data;
        end else if (src_idx != NULL_IDX) begin
            copy_val = regs_q[src_idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        xfer        = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (mode)
                    MODE_IMM: begin
                        regs_d[0] = DATA_WIDTH'(ir_q[5:0]);
                        pc_d      = pc_inc;
                        state_d   = ST_FETCH;
                    end
                    MODE_CALC: begin
                        regs_d[3] = alu_out;
                        pc_d      = pc_inc;
                        state_d   = ST_FETCH;
                    end
                    MODE_COPY: begin
                        xfer = !src_is_io || in_valid;
                        if (!xfer) begin
                            state_d = ST_WAIT_IN;
                        end
                    end
                    MODE_COND: begin
                        pc_d    = cond_taken ? PC_WIDTH'(regs_q[0]) : pc_inc;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_WAIT_IN: begin
                xfer = in_valid;
            end
            ST_WAIT_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_inc;
                    state_d     = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // A copy whose source is available lands here; an IO destination
        // defers pc advance until the output word is accepted.
        if (xfer) begin
            if (dst_idx == IO_IDX) begin
                out_data_d  = copy_val;
                out_valid_d = 1'b1;
                state_d     = ST_WAIT_OUT;
            end else begin
                if (dst_idx != NULL_IDX) begin
                    regs_d[dst_idx] = copy_val;
                end
                pc_d    = pc_inc;
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            regs_q      <= regs_d;
        end
    end

endmodule

// File: tb/tb_overture_sequencer.sv
// Bench for overture_sequencer: directed instruction scenarios followed by a
// random program checked against an instruction-level reference model.
module tb_overture_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] imem_addr;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] alu_instr;
    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [7:0] alu_out;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dbg_pc;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] prog [256];
    logic [7:0] in_vals [$];
    logic [7:0] exp_q [$];
    logic [7:0] exp_pc_q [$];
    logic [7:0] exp_r1_q [$];
    logic [7:0] exp_r2_q [$];
    int         exp_in_cnt_q [$];
    int         exp_out_cnt_q [$];

    localparam int RAND_INSTRS = 200;

    always #5 clk = ~clk;

    overture_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .alu_instr (alu_instr),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_out   (alu_out),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dbg_pc    (dbg_pc)
    );

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a | b;
            3'd1:    return ~(a & b);
            3'd2:    return ~(a | b);
            3'd3:    return a & b;
            3'd4:    return a + b;
            3'd5:    return a - b;
            default: return 8'h00;
        endcase
    endfunction

    // External ALU stand-in.
    always_comb alu_out = alu_fn(alu_instr[2:0], alu_in1, alu_in2);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_imem();
        #1;
        imem_ack  = imem_req;
        imem_data = prog[imem_addr];
    endtask

    task automatic tick();
        @(negedge clk);
        drive_imem();
    endtask

    // Runs until n instructions have completed; stops with the next fetch pending.
    task automatic run_instrs(input int n, output int cycles);
        int  cnt = 0;
        bit  timed_out = 1'b0;
        cycles = 0;
        drive_imem();
        while (1) begin
            if (imem_ack) begin
                if (cnt == n) break;
                cnt++;
            end
            if (cycles > 200) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            drive_imem();
            cycles++;
        end
        n_total++;
        if (timed_out) $display("FAIL run_instrs_timeout got %0d instrs want %0d", cnt, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (dbg_pc !== 8'h00) $display("FAIL reset_pc got %h want 00", dbg_pc); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", out_data); else n_pass++;
        n_total++; if (alu_instr !== 8'h00) $display("FAIL reset_ir got %h want 00", alu_instr); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_first_two();
        int cyc;
        run_instrs(2, cyc);
        n_total++; if (cyc !== 4) $display("FAIL first_cycles got %0d want 4", cyc); else n_pass++;
        n_total++; if (dbg_pc !== 8'h02) $display("FAIL first_pc got %h want 02", dbg_pc); else n_pass++;
        n_total++; if (dut.regs_q[0] !== 8'h05) $display("FAIL first_r0 got %h want 05", dut.regs_q[0]); else n_pass++;
        n_total++; if (alu_in1 !== 8'h05) $display("FAIL first_r1 got %h want 05", alu_in1); else n_pass++;
    endtask

    task automatic test_calc();
        int cyc;
        in_valid = 1'b1;
        in_data  = 8'h80;
        run_instrs(4, cyc);
        in_valid = 1'b0;
        n_total++; if (alu_in1 !== 8'h80) $display("FAIL calc_r1 got %h want 80", alu_in1); else n_pass++;
        n_total++; if (alu_in2 !== 8'h01) $display("FAIL calc_r2 got %h want 01", alu_in2); else n_pass++;
        n_total++; if (dut.regs_q[3] !== 8'h7F) $display("FAIL calc_sub_r3 got %h want 7f", dut.regs_q[3]); else n_pass++;
        run_instrs(1, cyc);
        n_total++; if (dut.regs_q[3] !== 8'h00) $display("FAIL calc_op6_r3 got %h want 00", dut.regs_q[3]); else n_pass++;
        n_total++; if (dbg_pc !== 8'h07) $display("FAIL calc_pc got %h want 07", dbg_pc); else n_pass++;
    endtask

    task automatic test_cond();
        int cyc;
        run_instrs(3, cyc);
        n_total++; if (dut.regs_q[3] !== 8'hFF) $display("FAIL cond_r3 got %h want ff", dut.regs_q[3]); else n_pass++;
        n_total++; if (dbg_pc !== 8'h10) $display("FAIL cond_ltz_taken_pc got %h want 10", dbg_pc); else n_pass++;
        run_instrs(2, cyc);
        n_total++; if (dbg_pc !== 8'h12) $display("FAIL cond_gtz_not_taken_pc got %h want 12", dbg_pc); else n_pass++;
    endtask

    task automatic test_copy_in_wait();
        int cyc;
        in_valid = 1'b0;
        tick();
        n_total++; if (in_ready !== 1'b1) $display("FAIL copy_in_ready_exec got %b want 1", in_ready); else n_pass++;
        repeat (3) begin
            tick();
            n_total++; if (dbg_pc !== 8'h12) $display("FAIL copy_in_pc_frozen got %h want 12", dbg_pc); else n_pass++;
            n_total++; if (in_ready !== 1'b1) $display("FAIL copy_in_ready_wait got %b want 1", in_ready); else n_pass++;
        end
        n_total++; if (dut.regs_q[0] !== 8'h10) $display("FAIL copy_in_r0_early got %h want 10", dut.regs_q[0]); else n_pass++;
        in_valid = 1'b1;
        in_data  = 8'h2A;
        run_instrs(0, cyc);
        in_valid = 1'b0;
        n_total++; if (dut.regs_q[0] !== 8'h2A) $display("FAIL copy_in_r0 got %h want 2a", dut.regs_q[0]); else n_pass++;
        n_total++; if (dbg_pc !== 8'h13) $display("FAIL copy_in_pc got %h want 13", dbg_pc); else n_pass++;
    endtask

    task automatic test_copy_out_wait();
        out_ready = 1'b0;
        tick();
        tick();
        repeat (5) begin
            n_total++; if (out_valid !== 1'b1) $display("FAIL copy_out_valid got %b want 1", out_valid); else n_pass++;
            n_total++; if (out_data !== 8'h2A) $display("FAIL copy_out_data got %h want 2a", out_data); else n_pass++;
            n_total++; if (dbg_pc !== 8'h13) $display("FAIL copy_out_pc_frozen got %h want 13", dbg_pc); else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL copy_out_drop got %b want 0", out_valid); else n_pass++;
        n_total++; if (dbg_pc !== 8'h14) $display("FAIL copy_out_pc got %h want 14", dbg_pc); else n_pass++;
    endtask

    task automatic test_pc_wrap();
        int cyc;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        run_instrs(2, cyc);
        in_valid = 1'b0;
        n_total++; if (dbg_pc !== 8'hFF) $display("FAIL wrap_jump_pc got %h want ff", dbg_pc); else n_pass++;
        run_instrs(1, cyc);
        n_total++; if (dbg_pc !== 8'h00) $display("FAIL wrap_pc got %h want 00", dbg_pc); else n_pass++;
        n_total++; if (dut.regs_q[0] !== 8'h07) $display("FAIL wrap_r0 got %h want 07", dut.regs_q[0]); else n_pass++;
    endtask

    task automatic test_reset_wait_out();
        prog[0] = 8'h86;
        prog[1] = 8'h86;
        drive_imem();
        out_ready = 1'b0;
        tick();
        tick();
        n_total++; if (out_valid !== 1'b1) $display("FAIL rstout_valid got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_data !== 8'h07) $display("FAIL rstout_data got %h want 07", out_data); else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        n_total++; if (out_valid !== 1'b1 || dbg_pc !== 8'h01) $display("FAIL rstout_second got v=%b pc=%h want v=1 pc=01", out_valid, dbg_pc); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        imem_ack = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rstout_async_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (dbg_pc !== 8'h00) $display("FAIL rstout_async_pc got %h want 00", dbg_pc); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL rstout_imem_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (dut.regs_q[0] !== 8'h00) $display("FAIL rstout_r0 got %h want 00", dut.regs_q[0]); else n_pass++;
    endtask

    // Instruction-level reference: executes k instructions from pc 0 and
    // records the architectural state expected at the start of each one.
    task automatic model_run(input int k);
        logic [7:0] r [8];
        logic [7:0] pc;
        logic [7:0] ins;
        logic [7:0] v;
        logic [2:0] src;
        logic [2:0] dst;
        int         ip;
        int         s;
        bit         taken;
        for (int i = 0; i < 8; i++) r[i] = 8'h00;
        pc = 8'h00;
        ip = 0;
        exp_q.delete(); exp_pc_q.delete(); exp_r1_q.delete(); exp_r2_q.delete();
        exp_in_cnt_q.delete(); exp_out_cnt_q.delete();
        for (int i = 0; i < k; i++) begin
            exp_pc_q.push_back(pc);
            exp_r1_q.push_back(r[1]);
            exp_r2_q.push_back(r[2]);
            exp_in_cnt_q.push_back(ip);
            exp_out_cnt_q.push_back(exp_q.size());
            ins = prog[pc];
            case (ins[7:6])
                2'd0: begin r[0] = {2'b00, ins[5:0]}; pc = pc + 8'd1; end
                2'd1: begin r[3] = alu_fn(ins[2:0], r[1], r[2]); pc = pc + 8'd1; end
                2'd2: begin
                    src = ins[5:3];
                    dst = ins[2:0];
                    if (src == 3'd7) v = 8'h00;
                    else if (src == 3'd6) begin v = in_vals[ip]; ip++; end
                    else v = r[src];
                    if (dst == 3'd6) exp_q.push_back(v);
                    else if (dst != 3'd7) r[dst] = v;
                    pc = pc + 8'd1;
                end
                default: begin
                    s = int'($signed(r[3]));
                    case (ins[2:0])
                        3'd0: taken = 1'b0;
                        3'd1: taken = (s == 0);
                        3'd2: taken = (s < 0);
                        3'd3: taken = (s <= 0);
                        3'd4: taken = 1'b1;
                        3'd5: taken = (s != 0);
                        3'd6: taken = (s >= 0);
                        default: taken = (s > 0);
                    endcase
                    pc = taken ? r[0] : pc + 8'd1;
                end
            endcase
        end
    endtask

    task automatic test_random_program();
        int f = 0;
        int cyc = 0;
        int in_ptr = 0;
        int out_ptr = 0;
        int lat = 0;
        bit in_fire = 1'b0;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
        in_vals.delete();
        for (int i = 0; i < 400; i++) in_vals.push_back(8'($urandom));
        model_run(RAND_INSTRS);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        while (f < RAND_INSTRS && cyc < 20000) begin
            @(negedge clk);
            #1;
            cyc++;
            if (in_fire) in_ptr++;
            if (imem_req) begin
                if (lat == 0) begin
                    imem_ack  = 1'b1;
                    imem_data = prog[imem_addr];
                    n_total++; if (imem_addr !== exp_pc_q[f]) $display("FAIL rand_pc #%0d got %h want %h", f, imem_addr, exp_pc_q[f]); else n_pass++;
                    n_total++; if (alu_in1 !== exp_r1_q[f]) $display("FAIL rand_r1 #%0d got %h want %h", f, alu_in1, exp_r1_q[f]); else n_pass++;
                    n_total++; if (alu_in2 !== exp_r2_q[f]) $display("FAIL rand_r2 #%0d got %h want %h", f, alu_in2, exp_r2_q[f]); else n_pass++;
                    n_total++; if (in_ptr !== exp_in_cnt_q[f]) $display("FAIL rand_in_count #%0d got %0d want %0d", f, in_ptr, exp_in_cnt_q[f]); else n_pass++;
                    n_total++; if (out_ptr !== exp_out_cnt_q[f]) $display("FAIL rand_out_count #%0d got %0d want %0d", f, out_ptr, exp_out_cnt_q[f]); else n_pass++;
                    f++;
                    lat = $urandom_range(0, 2);
                end else begin
                    imem_ack = 1'b0;
                    lat--;
                end
            end else begin
                imem_ack  = 1'($urandom_range(0, 1));
                imem_data = 8'($urandom);
            end
            if (in_ptr < in_vals.size() && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = in_vals[in_ptr];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            in_fire   = in_valid && in_ready;
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                n_total++;
                if (out_ptr >= exp_q.size()) $display("FAIL rand_out_extra got %h want none", out_data);
                else if (out_data !== exp_q[out_ptr]) $display("FAIL rand_out_data #%0d got %h want %h", out_ptr, out_data, exp_q[out_ptr]);
                else n_pass++;
                out_ptr++;
            end
        end
        n_total++; if (f < RAND_INSTRS) $display("FAIL rand_timeout got %0d fetches want %0d", f, RAND_INSTRS); else n_pass++;
        imem_ack  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
        prog[8'h00] = 8'h05; prog[8'h01] = 8'h81;
        prog[8'h02] = 8'hB1; prog[8'h03] = 8'h01; prog[8'h04] = 8'h82;
        prog[8'h05] = 8'h45; prog[8'h06] = 8'h46;
        prog[8'h07] = 8'h41; prog[8'h08] = 8'h10; prog[8'h09] = 8'hC2;
        prog[8'h10] = 8'h46; prog[8'h11] = 8'hC7;
        prog[8'h12] = 8'hB0; prog[8'h13] = 8'h86;
        prog[8'h14] = 8'hB0; prog[8'h15] = 8'hC4; prog[8'hFF] = 8'h07;

        test_reset();
        test_first_two();
        test_calc();
        test_cond();
        test_copy_in_wait();
        test_copy_out_wait();
        test_pc_wrap();
        test_reset_wait_out();
        test_random_program();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
